// File: rtl/video_compositor_if.sv
// Bundle of the video, layer and configuration signals of the compositor.
// The compositor uses the slave modport; the pixel source / host uses master.
interface video_compositor_if #(
   parameter int NUM_LAYERS = 2,
   parameter int COLOR_W    = 4
);
   logic                              vga_hsync_i;
   logic                              vga_vsync_i;
   logic                              vga_de_i;
   logic [NUM_LAYERS*3*COLOR_W-1:0]   layer_rgb_i;
   logic [NUM_LAYERS-1:0]             layer_valid_i;
   logic                              cfg_wr_i;
   logic [3:0]                        cfg_addr_i;
   logic [31:0]                       cfg_data_i;

   logic                              vga_hsync_o;
   logic                              vga_vsync_o;
   logic                              vga_de_o;
   logic [COLOR_W-1:0]                vga_r_o;
   logic [COLOR_W-1:0]                vga_g_o;
   logic [COLOR_W-1:0]                vga_b_o;
   logic                              frame_o;
   logic [15:0]                       underflow_cnt_o;

   modport master (
      output vga_hsync_i, vga_vsync_i, vga_de_i, layer_rgb_i, layer_valid_i,
             cfg_wr_i, cfg_addr_i, cfg_data_i,
      input  vga_hsync_o, vga_vsync_o, vga_de_o, vga_r_o, vga_g_o, vga_b_o,
             frame_o, underflow_cnt_o
   );

   modport slave (
      input  vga_hsync_i, vga_vsync_i, vga_de_i, layer_rgb_i, layer_valid_i,
             cfg_wr_i, cfg_addr_i, cfg_data_i,
      output vga_hsync_o, vga_vsync_o, vga_de_o, vga_r_o, vga_g_o, vga_b_o,
             frame_o, underflow_cnt_o
   );
endinterface

// File: rtl/video_compositor.sv
// Priority-ordered layer compositor with per-layer colour keying, frame-synchronous
// double-buffered configuration and per-frame underflow statistics; 2-cycle pipeline.
module video_compositor #(
   parameter int NUM_LAYERS = 2,
   parameter int COLOR_W    = 4
) (
   input  logic               clk,
   input  logic               reset_i,
   video_compositor_if.slave  bus
);
   localparam int PIX_W = 3 * COLOR_W;

   // Staging (host-written) and active (frame-latched) configuration
   logic [NUM_LAYERS-1:0]             layer_en_stg_reg;
   logic [NUM_LAYERS-1:0]             key_en_stg_reg;
   logic [PIX_W-1:0]                  bg_stg_reg;
   logic [NUM_LAYERS-1:0][PIX_W-1:0]  key_stg_reg;
   logic [NUM_LAYERS-1:0]             layer_en_act_reg;
   logic [NUM_LAYERS-1:0]             key_en_act_reg;
   logic [PIX_W-1:0]                  bg_act_reg;
   logic [NUM_LAYERS-1:0][PIX_W-1:0]  key_act_reg;

   logic                              prev_vsync_reg;
   logic                              boundary;
   logic                              frame_reg;
   logic [15:0]                       run_cnt_reg;
   logic [15:0]                       underflow_cnt_reg;
   logic                              any_underflow;
   logic                              unused_cfg;

   logic [NUM_LAYERS-1:0]             opaque;
   logic [2:0]                        s1_sync_reg;
   logic [NUM_LAYERS*PIX_W-1:0]       s1_rgb_reg;
   logic [NUM_LAYERS-1:0]             s1_opaque_reg;
   logic [PIX_W-1:0]                  s1_bg_reg;
   logic [PIX_W-1:0]                  sel_pix;
   logic [2:0]                        out_sync_reg;
   logic [PIX_W-1:0]                  out_rgb_reg;

   // prev_vsync resets to 0, so a vsync held high through reset release is not a boundary
   assign boundary      = prev_vsync_reg & ~bus.vga_vsync_i;
   assign any_underflow = |(layer_en_act_reg & ~bus.layer_valid_i);
   assign unused_cfg    = ^bus.cfg_data_i;

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         layer_en_stg_reg <= '1;
         key_en_stg_reg   <= '1;
         bg_stg_reg       <= '0;
         key_stg_reg      <= '0;
         layer_en_act_reg <= '1;
         key_en_act_reg   <= '1;
         bg_act_reg       <= '0;
         key_act_reg      <= '0;
      end else begin
         // Active set takes the staging values as they were before any same-edge write
         if (boundary) begin
            layer_en_act_reg <= layer_en_stg_reg;
            key_en_act_reg   <= key_en_stg_reg;
            bg_act_reg       <= bg_stg_reg;
            key_act_reg      <= key_stg_reg;
         end
         if (bus.cfg_wr_i) begin
            if (bus.cfg_addr_i == 4'd0) begin
               layer_en_stg_reg <= bus.cfg_data_i[NUM_LAYERS-1:0];
               key_en_stg_reg   <= bus.cfg_data_i[8 +: NUM_LAYERS];
            end
            if (bus.cfg_addr_i == 4'd1) begin
               bg_stg_reg <= bus.cfg_data_i[PIX_W-1:0];
            end
            for (int i = 0; i < NUM_LAYERS; i++) begin
               if (bus.cfg_addr_i == 4'(i + 2)) begin
                  key_stg_reg[i] <= bus.cfg_data_i[PIX_W-1:0];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         prev_vsync_reg    <= 1'b0;
         frame_reg         <= 1'b0;
         run_cnt_reg       <= '0;
         underflow_cnt_reg <= '0;
      end else begin
         prev_vsync_reg <= bus.vga_vsync_i;
         frame_reg      <= boundary;
         if (boundary) begin
            underflow_cnt_reg <= run_cnt_reg;
            run_cnt_reg       <= '0;
         end else if (bus.vga_de_i && any_underflow && (run_cnt_reg != 16'hFFFF)) begin
            run_cnt_reg <= run_cnt_reg + 16'd1;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_opaque
         logic [PIX_W-1:0] pix;
         assign pix         = bus.layer_rgb_i[gi*PIX_W +: PIX_W];
         assign opaque[gi]  = layer_en_act_reg[gi] & bus.layer_valid_i[gi] &
                              (~key_en_act_reg[gi] | (pix != key_act_reg[gi]));
      end
   endgenerate

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         s1_sync_reg   <= '0;
         s1_rgb_reg    <= '0;
         s1_opaque_reg <= '0;
         s1_bg_reg     <= '0;
      end else begin
         s1_sync_reg   <= {bus.vga_hsync_i, bus.vga_vsync_i, bus.vga_de_i};
         s1_rgb_reg    <= bus.layer_rgb_i;
         s1_opaque_reg <= opaque;
         s1_bg_reg     <= bg_act_reg;
      end
   end

   // Walk from lowest to highest priority so layer 0 wins
   always_comb begin
      sel_pix = s1_bg_reg;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (s1_opaque_reg[i]) begin
            sel_pix = s1_rgb_reg[i*PIX_W +: PIX_W];
         end
      end
   end

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         out_sync_reg <= '0;
         out_rgb_reg  <= '0;
      end else begin
         out_sync_reg <= s1_sync_reg;
         out_rgb_reg  <= s1_sync_reg[0] ? sel_pix : '0;
      end
   end

   assign bus.vga_hsync_o     = out_sync_reg[2];
   assign bus.vga_vsync_o     = out_sync_reg[1];
   assign bus.vga_de_o        = out_sync_reg[0];
   assign bus.vga_r_o         = out_rgb_reg[PIX_W-1 -: COLOR_W];
   assign bus.vga_g_o         = out_rgb_reg[2*COLOR_W-1 -: COLOR_W];
   assign bus.vga_b_o         = out_rgb_reg[COLOR_W-1:0];
   assign bus.frame_o         = frame_reg;
   assign bus.underflow_cnt_o = underflow_cnt_reg;
endmodule

// File: tb/tb_video_compositor.sv
// Scoreboard bench for video_compositor (2 layers, 4-bit colour): a behavioural model
// pushes expected pixels/timing/frame/underflow per driven cycle, a negedge checker pops them.
module tb_video_compositor;
   localparam int NL = 2;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic reset_i = 1'b1;
   always #5 clk = ~clk;

   video_compositor_if #(.NUM_LAYERS(NL), .COLOR_W(CW)) bus();
   video_compositor #(.NUM_LAYERS(NL), .COLOR_W(CW)) dut (
      .clk     (clk),
      .reset_i (reset_i),
      .bus     (bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc_n = 0;

   typedef struct { int cyc; logic [2:0] sync; logic [11:0] rgb; } pix_t;
   typedef struct { int cyc; logic frame; logic [15:0] ucnt; } frm_t;
   pix_t pq[$];
   frm_t fq[$];

   // Model state
   logic [1:0]  m_en_stg, m_ken_stg, m_en_act, m_ken_act;
   logic [11:0] m_bg_stg, m_bg_act;
   logic [11:0] m_key_stg [2];
   logic [11:0] m_key_act [2];
   logic        m_prev;
   logic [15:0] m_run, m_ucnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_en_stg = 2'b11; m_ken_stg = 2'b11; m_en_act = 2'b11; m_ken_act = 2'b11;
      m_bg_stg = '0; m_bg_act = '0;
      for (int i = 0; i < 2; i++) begin m_key_stg[i] = '0; m_key_act[i] = '0; end
      m_prev = 1'b0; m_run = '0; m_ucnt = '0;
   endtask

   task automatic idle_inputs();
      bus.vga_hsync_i = 0; bus.vga_vsync_i = 0; bus.vga_de_i = 0;
      bus.layer_rgb_i = '0; bus.layer_valid_i = 2'b11;
      bus.cfg_wr_i = 0; bus.cfg_addr_i = '0; bus.cfg_data_i = '0;
   endtask

   task automatic step(input logic vs, input logic de, input logic [11:0] l0, input logic [11:0] l1,
                       input logic [1:0] val, input logic wr = 1'b0,
                       input logic [3:0] addr = 4'd0, input logic [31:0] data = 32'd0);
      logic        hs;
      logic [11:0] pix [2];
      logic [11:0] rgb;
      logic        bnd;
      @(posedge clk);
      #1;
      hs = 1'($urandom);
      pix[0] = l0; pix[1] = l1;
      bus.vga_hsync_i = hs; bus.vga_vsync_i = vs; bus.vga_de_i = de;
      bus.layer_rgb_i = {l1, l0}; bus.layer_valid_i = val;
      bus.cfg_wr_i = wr; bus.cfg_addr_i = addr; bus.cfg_data_i = data;
      rgb = m_bg_act;
      for (int i = 1; i >= 0; i--)
         if (m_en_act[i] && val[i] && (!m_ken_act[i] || pix[i] != m_key_act[i])) rgb = pix[i];
      if (!de) rgb = '0;
      pq.push_back('{cyc_n, {hs, vs, de}, rgb});
      bnd = m_prev && !vs;
      if (bnd) begin
         m_ucnt = m_run; m_run = '0;
      end else if (de && ((m_en_act & ~val) != 2'b00) && m_run != 16'hFFFF) begin
         m_run = m_run + 16'd1;
      end
      fq.push_back('{cyc_n, bnd, m_ucnt});
      if (bnd) begin
         m_en_act = m_en_stg; m_ken_act = m_ken_stg; m_bg_act = m_bg_stg;
         m_key_act[0] = m_key_stg[0]; m_key_act[1] = m_key_stg[1];
      end
      if (wr) begin
         case (addr)
            4'd0: begin m_en_stg = data[1:0]; m_ken_stg = data[9:8]; end
            4'd1: m_bg_stg = data[11:0];
            4'd2: m_key_stg[0] = data[11:0];
            4'd3: m_key_stg[1] = data[11:0];
            default: ;
         endcase
      end
      m_prev = vs;
   endtask

   task automatic cfg(input logic [3:0] addr, input logic [31:0] data);
      step(0, 0, 12'h000, 12'h000, 2'b11, 1'b1, addr, data);
   endtask

   task automatic vsync_pulse();
      step(1, 0, 12'h000, 12'h000, 2'b11);
      step(0, 0, 12'h000, 12'h000, 2'b11);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_rgb"},  {20'd0, bus.vga_r_o, bus.vga_g_o, bus.vga_b_o}, 32'd0);
      check({tag, "_sync"}, {29'd0, bus.vga_hsync_o, bus.vga_vsync_o, bus.vga_de_o}, 32'd0);
      check({tag, "_frame"}, {31'd0, bus.frame_o}, 32'd0);
      check({tag, "_ucnt"}, {16'd0, bus.underflow_cnt_o}, 32'd0);
   endtask

   always @(posedge clk) cyc_n <= cyc_n + 1;

   always @(negedge clk) begin
      if (!reset_i) begin
         if (pq.size() > 0 && cyc_n >= pq[0].cyc + 2) begin
            pix_t p;
            p = pq.pop_front();
            check("rgb",  {20'd0, bus.vga_r_o, bus.vga_g_o, bus.vga_b_o}, {20'd0, p.rgb});
            check("sync", {29'd0, bus.vga_hsync_o, bus.vga_vsync_o, bus.vga_de_o}, {29'd0, p.sync});
         end
         if (fq.size() > 0 && cyc_n >= fq[0].cyc + 1) begin
            frm_t f;
            f = fq.pop_front();
            check("frame", {31'd0, bus.frame_o}, {31'd0, f.frame});
            check("ucnt",  {16'd0, bus.underflow_cnt_o}, {16'd0, f.ucnt});
         end
      end
   end

   initial begin
      idle_inputs();
      model_reset();
      #12;
      check_outputs_zero("reset");
      @(posedge clk); #3;
      reset_i = 1'b0;

      // Defaults: black keyed out on every layer
      step(0, 1, 12'h000, 12'h5A3, 2'b11);
      step(0, 1, 12'h00F, 12'h5A3, 2'b11);
      step(0, 0, 12'h00F, 12'h5A3, 2'b11);

      // Key change takes effect only after the vsync fall
      cfg(4'd2, 32'h0000_00F0);
      cfg(4'd0, 32'h0000_0003);
      step(0, 1, 12'h0F0, 12'h123, 2'b11);
      vsync_pulse();
      step(0, 1, 12'h0F0, 12'h123, 2'b11);
      step(0, 1, 12'h000, 12'h123, 2'b11);

      // Layer 0 disabled, layer 1 shown; then keyed layer 1 reveals BG
      cfg(4'd0, 32'h0000_0102);
      cfg(4'd1, 32'h0000_0321);
      vsync_pulse();
      step(0, 1, 12'h0AA, 12'h000, 2'b11);
      step(0, 1, 12'h0AA, 12'h444, 2'b11);
      cfg(4'd0, 32'h0000_0202);
      vsync_pulse();
      step(0, 1, 12'h0AA, 12'h000, 2'b11);

      // BG write on the boundary edge: old BG this frame, new BG next frame
      step(1, 0, 12'h000, 12'h000, 2'b11);
      step(0, 0, 12'h000, 12'h000, 2'b11, 1'b1, 4'd1, 32'h0000_0ABC);
      step(0, 1, 12'h000, 12'h000, 2'b11);
      vsync_pulse();
      step(0, 1, 12'h000, 12'h000, 2'b11);

      // Underflow statistics over two frames
      for (int i = 0; i < 100; i++) step(0, 1, 12'h111, 12'h222, 2'b01);
      step(0, 0, 12'h111, 12'h222, 2'b00);
      vsync_pulse();
      for (int i = 0; i < 10; i++) step(0, 1, 12'h111, 12'h222, 2'b11);
      vsync_pulse();
      step(0, 0, 12'h000, 12'h000, 2'b11);

      // Randomised traffic with occasional config writes (including unmapped addresses)
      for (int i = 0; i < 300; i++) begin
         logic [11:0] l0, l1, kv;
         logic [3:0]  a;
         l0 = ($urandom_range(0, 2) == 0) ? 12'h000 : 12'($urandom);
         l1 = ($urandom_range(0, 2) == 0) ? 12'h0F0 : 12'($urandom);
         a  = 4'($urandom_range(0, 15));
         kv = ($urandom_range(0, 1) == 0) ? 12'h000 : 12'h0F0;
         step(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0), l0, l1,
              2'($urandom), 1'($urandom_range(0, 4) == 0), a,
              (a >= 4'd2) ? {20'd0, kv} : $urandom);
      end

      // Asynchronous reset mid-line
      step(0, 1, 12'h0F0, 12'h123, 2'b11);
      step(0, 1, 12'h0F0, 12'h123, 2'b11);
      #2;
      reset_i = 1'b1;
      pq.delete();
      fq.delete();
      #1;
      check_outputs_zero("async_rst");
      idle_inputs();
      bus.vga_vsync_i = 1'b1;
      @(posedge clk); @(posedge clk); #3;
      bus.vga_vsync_i = 1'b0;
      model_reset();
      reset_i = 1'b0;
      step(0, 1, 12'h000, 12'h5A3, 2'b11);
      step(1, 1, 12'h00F, 12'h5A3, 2'b11);
      step(0, 1, 12'h000, 12'h000, 2'b11);
      step(0, 0, 12'h00F, 12'h5A3, 2'b10);

      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      check("drain", pq.size() + fq.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
